// File: rtl/branch_resolve_ctrl_if.sv
// Handshake bundle between execute (branch issue), the resolver and fetch (redirect).
// The master side is execute/fetch. The slave side is the branch resolver.
interface branch_resolve_ctrl_if;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_inst;
   logic [3:0]  ex_br_type;
   logic [31:0] ex_src1;
   logic [31:0] ex_src2;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        redirect_valid;
   logic        redirect_ready;
   logic [31:0] redirect_pc;

   modport master (
      output ex_valid, ex_pc, ex_inst, ex_br_type, ex_src1, ex_src2,
             ex_pred_taken, ex_pred_target, redirect_ready,
      input  ex_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  ex_valid, ex_pc, ex_inst, ex_br_type, ex_src1, ex_src2,
             ex_pred_taken, ex_pred_target, redirect_ready,
      output ex_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolver: computes the actual direction and target and issues a predictor
// update and a link write. On a mispredict it pulses a flush and holds a redirect to fetch.
module branch_resolve_ctrl (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush_in,
   branch_resolve_ctrl_if.slave        br,
   output logic                        flush_out,
   output logic                        upd_valid,
   output logic [31:0]                 upd_pc,
   output logic [31:0]                 upd_target,
   output logic                        upd_taken,
   output logic                        wb_valid,
   output logic [4:0]                  wb_addr,
   output logic [31:0]                 wb_data,
   output logic [31:0]                 mispredict_cnt
);

   typedef enum logic {IDLE, REDIR} state_t;

   localparam logic [3:0] BR_BEQ  = 4'd1;
   localparam logic [3:0] BR_BNE  = 4'd2;
   localparam logic [3:0] BR_BLT  = 4'd3;
   localparam logic [3:0] BR_BGE  = 4'd4;
   localparam logic [3:0] BR_BLTU = 4'd5;
   localparam logic [3:0] BR_BGEU = 4'd6;
   localparam logic [3:0] BR_B    = 4'd7;
   localparam logic [3:0] BR_BL   = 4'd8;
   localparam logic [3:0] BR_JIRL = 4'd9;

   state_t      state_q;
   logic        redirect_valid_q;
   logic [31:0] redirect_pc_q;
   logic        flush_out_q;
   logic        upd_valid_q;
   logic [31:0] upd_pc_q;
   logic [31:0] upd_target_q;
   logic        upd_taken_q;
   logic        wb_valid_q;
   logic [4:0]  wb_addr_q;
   logic [31:0] wb_data_q;
   logic [31:0] mispredict_cnt_q;

   logic        accept;
   logic        legal;
   logic        taken;
   logic        mispredict;
   logic        is_link;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic [31:0] sext16;
   logic [31:0] sext26;
   logic [25:0] offs26;
   logic        unused_inst_bits;

   // Opcode bits are already decoded into ex_br_type and are not needed here.
   assign unused_inst_bits = ^br.ex_inst[31:26];

   assign br.ex_ready = (state_q == IDLE) && !flush_in;
   assign accept      = br.ex_valid && br.ex_ready;

   // Offsets are word offsets: shift left by 2, then sign-extend to 32 bits.
   assign offs26   = {br.ex_inst[9:0], br.ex_inst[25:10]};
   assign sext16   = {{14{br.ex_inst[25]}}, br.ex_inst[25:10], 2'b00};
   assign sext26   = {{4{offs26[25]}}, offs26, 2'b00};
   assign pc_plus4 = br.ex_pc + 32'd4;

   // Resolve direction and target of the presented instruction.
   always_comb begin
      legal  = 1'b1;
      taken  = 1'b0;
      target = br.ex_pc + sext16;
      case (br.ex_br_type)
         BR_BEQ:  taken = (br.ex_src1 == br.ex_src2);
         BR_BNE:  taken = (br.ex_src1 != br.ex_src2);
         BR_BLT:  taken = ($signed(br.ex_src1) <  $signed(br.ex_src2));
         BR_BGE:  taken = ($signed(br.ex_src1) >= $signed(br.ex_src2));
         BR_BLTU: taken = (br.ex_src1 <  br.ex_src2);
         BR_BGEU: taken = (br.ex_src1 >= br.ex_src2);
         BR_B, BR_BL: begin
            taken  = 1'b1;
            target = br.ex_pc + sext26;
         end
         BR_JIRL: begin
            taken  = 1'b1;
            target = br.ex_src1 + sext16;
         end
         default: legal = 1'b0;
      endcase
   end

   assign is_link    = (br.ex_br_type == BR_BL) || (br.ex_br_type == BR_JIRL);
   assign mispredict = legal && ((taken != br.ex_pred_taken) ||
                                 (taken && (target != br.ex_pred_target)));

   // Redirect FSM: hold the correct PC toward fetch until accepted or flushed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && mispredict) begin
                  state_q          <= REDIR;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= taken ? target : pc_plus4;
               end
            end
            REDIR: begin
               if (flush_in || br.redirect_ready) begin
                  state_q          <= IDLE;
                  redirect_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q          <= IDLE;
               redirect_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Registered update/link/flush pulses and the saturating mispredict counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_out_q      <= 1'b0;
         upd_valid_q      <= 1'b0;
         upd_pc_q         <= 32'd0;
         upd_target_q     <= 32'd0;
         upd_taken_q      <= 1'b0;
         wb_valid_q       <= 1'b0;
         wb_addr_q        <= 5'd0;
         wb_data_q        <= 32'd0;
         mispredict_cnt_q <= 32'd0;
      end else begin
         flush_out_q <= accept && mispredict;
         upd_valid_q <= accept && legal;
         wb_valid_q  <= accept && legal && is_link;
         if (accept && legal) begin
            upd_pc_q     <= br.ex_pc;
            upd_target_q <= target;
            upd_taken_q  <= taken;
            wb_addr_q    <= (br.ex_br_type == BR_BL) ? 5'd1 : br.ex_inst[4:0];
            wb_data_q    <= pc_plus4;
         end
         if (accept && mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
            mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
         end
      end
   end

   assign br.redirect_valid = redirect_valid_q;
   assign br.redirect_pc    = redirect_pc_q;
   assign flush_out         = flush_out_q;
   assign upd_valid         = upd_valid_q;
   assign upd_pc            = upd_pc_q;
   assign upd_target        = upd_target_q;
   assign upd_taken         = upd_taken_q;
   assign wb_valid          = wb_valid_q;
   assign wb_addr           = wb_addr_q;
   assign wb_data           = wb_data_q;
   assign mispredict_cnt    = mispredict_cnt_q;

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequences branch and jump resolution between the execute stage and the front end. It accepts one decoded branch-class instruction per handshake (BEQ/BNE/BLT/BGE/BLTU/BGEU/B/BL/JIRL) with its operands and prediction. It computes the actual direction and target and issues the predictor update and link-register write. On a mispredict it raises a flush and holds a redirect request until fetch accepts it.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush_in  in  1  external flush (exception/ertn); aborts any pending redirect
- ex_valid  in  1  branch instruction presented
- ex_ready  out  1  controller can accept; equals (state==IDLE) && !flush_in
- ex_pc  in  32  instruction PC
- ex_inst  in  32  raw instruction word
- ex_br_type  in  4  1=BEQ 2=BNE 3=BLT 4=BGE 5=BLTU 6=BGEU 7=B 8=BL 9=JIRL; others illegal
- ex_src1  in  32  rj value
- ex_src2  in  32  rd value (compare operand)
- ex_pred_taken  in  1  front-end prediction
- ex_pred_target  in  32  predicted target
- redirect_valid  out  1  redirect request to fetch
- redirect_ready  in  1  fetch accepts redirect
- redirect_pc  out  32  correct next PC
- flush_out  out  1  one-cycle pulse: kill younger instructions
- upd_valid  out  1  one-cycle predictor update
- upd_pc / upd_target  out  32 each  branch PC / actual target
- upd_taken  out  1  actual direction
- wb_valid  out  1  one-cycle link write
- wb_addr  out  5  1 for BL, inst[4:0] for JIRL
- wb_data  out  32  ex_pc + 4
- mispredict_cnt  out  32  saturating count of mispredicts

## Operation
- Accept = ex_valid && ex_ready. Illegal ex_br_type on accept: treated as no-op (no update, no wb, no redirect).
- Offsets: offs16 = inst[25:10]; offs26 = {inst[9:0], inst[25:10]}. Sign-extend after shifting left by 2.
- Target: B/BL = pc + sext(offs26<<2). JIRL = src1 + sext(offs16<<2). Conditional = pc + sext(offs16<<2).
- Taken: BEQ src1==src2; BNE !=; BLT/BGE signed <, >=; BLTU/BGEU unsigned; B/BL/JIRL always.
- Mispredict = (taken != pred_taken) || (taken && target != pred_target).
- redirect_pc = taken ? target : pc+4. All 32-bit add wrap modulo 2^32.
- FSM: IDLE, REDIR.
  - IDLE: accept with mispredict -> REDIR; otherwise stay.
  - REDIR: redirect_valid=1. redirect_ready -> IDLE; flush_in -> IDLE, no handshake.
- redirect_valid and redirect_pc stay stable while in REDIR.
- flush_in in IDLE blocks accept; in REDIR it drops the request the next cycle.
- mispredict_cnt increments on each mispredicting accept and saturates at 0xFFFFFFFF.

## Timing
- Reset values: state IDLE; every output 0 except ex_ready, which is 1 when flush_in=0.
- Outputs are registered, one-cycle latency. For an accept at edge N, the following are valid in cycle N+1:
  - upd_*, wb_*, flush_out (pulse);
  - redirect_valid, together with the mispredict_cnt increment.
- upd_valid, wb_valid and flush_out are single-cycle pulses.
- Redirect handshake completes on the edge where redirect_valid && redirect_ready. redirect_valid is 0 the next cycle, and ex_ready returns to 1 the same cycle.
- Correctly predicted branches sustain one accept per cycle.
- Reset asserted mid-REDIR clears the request immediately (asynchronous).

## Test plan
- BEQ pc=0x1C000000, src1=src2=5, offs16=0x0004, pred_taken=1, pred_target=0x1C000010 -> upd_taken=1, upd_target=0x1C000010, no flush, next accept next cycle.
- BLT src1=0xFFFFFFFF, src2=1, pred_taken=0 -> taken; flush_out pulse; redirect_pc=target; redirect_valid held 3 cycles while redirect_ready=0; clears after ready; mispredict_cnt=1.
- BLTU with the same operands, pred_taken=1 -> not taken; redirect_pc=pc+4.
- BL pc=0x1C000100, offs26=-1 -> target 0x1C0000FC; wb_addr=1, wb_data=0x1C000104.
- JIRL rd=3, src1=0x80000000, offs16=0x0001, pred_target wrong -> redirect_pc=0x80000004; wb_addr=3.
- flush_in asserted in REDIR -> redirect_valid drops next cycle; ex_ready=0 while flush_in=1; reset mid-REDIR clears all outputs.
